tile_result_drain: RTL

// - Downstream stage of the tiled PE array. Accepts the per-tile lane result vectors that each PE tile

---
 rtl/acceltran_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 20 ++
 rtl/tile_result_drain.sv | 119 +++++++++++
 3 files changed

// File: rtl/acceltran_pkg.sv
// acceltran_pkg: shared word type and drain FSM state encoding for the tiled PE array
package acceltran_pkg;
  localparam int IL = 4;
  localparam int FL = 16;
  typedef logic signed [IL+FL-1:0] word_t;
  typedef enum logic [1:0] {IDLE, TAKE, STREAM} drain_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first set req searching upward from ptr+1 (mod N)
// Ports: req - request vector; ptr - last granted index;
//        gnt_onehot - one-hot grant (0 when no request); gnt_idx - granted index
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx
);
  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    for (int i = N; i >= 1; i--)
      if (req[(int'(ptr) + i) % N]) gnt_idx = IW'((int'(ptr) + i) % N);
    gnt_onehot = (|req) ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/tile_result_drain.sv
// tile_result_drain: round-robin capture of per-tile lane vectors, drained as one tagged serial stream
// Ports: clk/reset (async active-low); tile_valid/tile_data/cfg_lanes - tile side inputs;
//        PE_output_taken - one-cycle pulse to the granted tile; out_* - valid/ready word stream
//        tagged with tile, lane and last; busy - FSM not idle; drained_count - tiles fully drained
module tile_result_drain #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int tile  = 4,
  parameter int lanes = 16,
  parameter int W     = IL + FL,
  parameter int LW    = $clog2(lanes),
  parameter int TW    = (tile > 1) ? $clog2(tile) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [tile-1:0]     tile_valid,
  input  logic signed [W-1:0] tile_data [tile][lanes],
  input  logic [LW:0]         cfg_lanes,
  output logic [tile-1:0]     PE_output_taken,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic [TW-1:0]       out_tile,
  output logic [LW-1:0]       out_lane,
  output logic                out_last,
  output logic                busy,
  output logic [15:0]         drained_count
);
  import acceltran_pkg::*;
  drain_state_e state_q, state_d;
  logic [TW-1:0] ptr_q, ptr_d, g_q, g_d, gnt_idx;
  logic [tile-1:0] sel_q, sel_d, gnt_onehot;
  logic [LW:0] n_q, n_d, lane_nx;
  logic signed [W-1:0] cap_q [lanes];
  logic signed [W-1:0] cap_d [lanes];
  logic signed [W-1:0] out_data_q, out_data_d;
  logic [TW-1:0] out_tile_q, out_tile_d;
  logic [LW-1:0] out_lane_q, out_lane_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [15:0] drained_q, drained_d;
  logic grant, take, hs, adv, done;

  rr_arbiter #(.N(tile), .IW(TW)) u_arb (
    .req        (tile_valid),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  assign grant   = (state_q == IDLE) && (|tile_valid);
  assign take    = state_q == TAKE;
  assign hs      = out_valid_q && out_ready;
  assign adv     = hs && !out_last_q;
  assign done    = hs && out_last_q;
  assign lane_nx = {1'b0, out_lane_q} + (LW+1)'(1);

  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = grant ? TAKE : take ? STREAM : done ? IDLE : state_q;

  always_comb begin
    PE_output_taken = take ? sel_q : '0;
    busy            = state_q != IDLE;
  end

  // Lane count is frozen at grant; 0 or anything above the buffer depth means a full vector.
  always_comb begin
    g_d   = grant ? gnt_idx : g_q;
    sel_d = grant ? gnt_onehot : sel_q;
    n_d   = !grant ? n_q
          : (cfg_lanes == '0 || cfg_lanes > (LW+1)'(lanes)) ? (LW+1)'(lanes) : cfg_lanes;
    cap_d = cap_q;
    if (grant) cap_d = tile_data[gnt_idx];
    ptr_d       = done ? g_q : ptr_q;
    drained_d   = drained_q + 16'(done);
    out_valid_d = take || (out_valid_q && !done);
    out_data_d  = take ? cap_q[0] : adv ? cap_q[lane_nx[LW-1:0]] : out_data_q;
    out_lane_d  = take ? '0 : adv ? lane_nx[LW-1:0] : out_lane_q;
    out_tile_d  = take ? g_q : out_tile_q;
    out_last_d  = take ? (n_q == (LW+1)'(1)) : adv ? (lane_nx == n_q - (LW+1)'(1)) : out_last_q;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ptr_q       <= TW'(tile - 1);
      g_q         <= '0;
      sel_q       <= '0;
      n_q         <= '0;
      cap_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tile_q  <= '0;
      out_lane_q  <= '0;
      out_last_q  <= 1'b0;
      drained_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      sel_q       <= sel_d;
      n_q         <= n_d;
      cap_q       <= cap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tile_q  <= out_tile_d;
      out_lane_q  <= out_lane_d;
      out_last_q  <= out_last_d;
      drained_q   <= drained_d;
    end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_tile      = out_tile_q;
  assign out_lane      = out_lane_q;
  assign out_last      = out_last_q;
  assign drained_count = drained_q;
endmodule
